// File: rtl/collision_detector_pkg.sv
// collision_detector_pkg: shared states, probe indices, offset table and off-map thresholds
// for the character collision scanner.
package collision_detector_pkg;

    typedef enum logic [1:0] {IDLE, PROBE, DRAIN, DONE} state_t;

    localparam logic [2:0] P_UP0    = 3'd0;
    localparam logic [2:0] P_UP1    = 3'd1;
    localparam logic [2:0] P_DOWN0  = 3'd2;
    localparam logic [2:0] P_DOWN1  = 3'd3;
    localparam logic [2:0] P_LEFT0  = 3'd4;
    localparam logic [2:0] P_LEFT1  = 3'd5;
    localparam logic [2:0] P_RIGHT0 = 3'd6;
    localparam logic [2:0] P_RIGHT1 = 3'd7;

    localparam logic [7:0] FLOOR_Y_MIN = 8'h80;
    localparam logic [7:0] SKY_Y_MIN   = 8'hF0;

    // Returns {dx, dy} as mod-256 offsets from the sprite's top-left corner.
    function automatic logic [15:0] probe_offset(input logic [2:0] idx, input int cw, input int ch);
        logic [7:0] w;
        logic [7:0] h;
        w = 8'(cw);
        h = 8'(ch);
        return idx == P_UP0    ? {8'h00, 8'hFF} :
               idx == P_UP1    ? {w - 8'd1, 8'hFF} :
               idx == P_DOWN0  ? {8'h00, h} :
               idx == P_DOWN1  ? {w - 8'd1, h} :
               idx == P_LEFT0  ? {8'hFF, 8'h00} :
               idx == P_LEFT1  ? {8'hFF, h - 8'd1} :
               idx == P_RIGHT0 ? {w, 8'h00} :
                                 {w, h - 8'd1};
    endfunction

endpackage

// File: rtl/collision_detector_probe_addr.sv
// collision_probe_addr: world coordinates, tile-map address and floor/sky classification
// for one probe of the snapshotted character position.
module collision_probe_addr
    import collision_detector_pkg::*;
#(
    parameter int CHAR_W     = 8,
    parameter int CHAR_H     = 16,
    parameter int TILE_SHIFT = 3
) (
    input  logic [2:0] i_idx,
    input  logic [7:0] i_x,
    input  logic [7:0] i_y,
    input  logic [7:0] i_scroll,
    output logic [8:0] o_map_addr,
    output logic       o_floor,
    output logic       o_sky
);
    logic [15:0] w_off;
    logic [7:0]  w_world_x;
    logic [7:0]  w_probe_y;

    assign w_off      = probe_offset(i_idx, CHAR_W, CHAR_H);
    assign w_world_x  = i_x + i_scroll + w_off[15:8];
    assign w_probe_y  = i_y + w_off[7:0];
    assign o_map_addr = {4'(w_probe_y >> TILE_SHIFT), 5'(w_world_x >> TILE_SHIFT)};
    assign o_floor    = w_probe_y >= FLOOR_Y_MIN && w_probe_y < SKY_Y_MIN;
    assign o_sky      = w_probe_y >= SKY_Y_MIN;

endmodule

// File: rtl/collision_detector.sv
// collision_detector: once-per-frame 8-probe tile-map scan producing registered
// up/down/left/right blocked flags for the player sprite.
module collision_detector
    import collision_detector_pkg::*;
#(
    parameter int CHAR_W     = 8,
    parameter int CHAR_H     = 16,
    parameter int TILE_SHIFT = 3
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] x_position,
    input  logic [7:0] y_position,
    input  logic [7:0] scroll_x,
    output logic [8:0] map_addr,
    output logic       map_rd,
    input  logic [1:0] map_data,
    output logic       busy,
    output logic       done,
    output logic       left_blocked,
    output logic       right_blocked,
    output logic       up_blocked,
    output logic       down_blocked
);
    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_idx;
    logic [7:0] r_x;
    logic [7:0] r_y;
    logic [7:0] r_scroll;
    logic [7:0] r_hits;
    logic [7:0] w_hits;
    logic       r_pv;
    logic [2:0] r_pi;
    logic       r_pf;
    logic       r_ps;
    logic [8:0] w_addr;
    logic       w_floor;
    logic       w_sky;
    logic       w_res;

    collision_probe_addr #(
        .CHAR_W    (CHAR_W),
        .CHAR_H    (CHAR_H),
        .TILE_SHIFT(TILE_SHIFT)
    ) u_probe (
        .i_idx     (r_idx),
        .i_x       (r_x),
        .i_y       (r_y),
        .i_scroll  (r_scroll),
        .o_map_addr(w_addr),
        .o_floor   (w_floor),
        .o_sky     (w_sky)
    );

    always_comb begin
        w_next = r_state;
        w_next = r_state == IDLE  ? (start ? PROBE : IDLE) :
                 r_state == PROBE ? (r_idx == P_RIGHT1 ? DRAIN : PROBE) :
                 r_state == DRAIN ? DONE : IDLE;
    end

    assign map_rd   = r_state == PROBE;
    assign map_addr = map_rd ? w_addr : '0;
    assign busy     = r_state != IDLE;
    assign done     = r_state == DONE;

    // Map data answers the probe issued one cycle earlier; off-map rows override it.
    assign w_res  = r_pf | (~r_ps & (|map_data));
    assign w_hits = r_hits | ({8{r_pv & w_res}} & (8'b1 << r_pi));

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state       <= IDLE;
            r_idx         <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_scroll      <= '0;
            r_hits        <= '0;
            r_pv          <= 1'b0;
            r_pi          <= '0;
            r_pf          <= 1'b0;
            r_ps          <= 1'b0;
            up_blocked    <= 1'b0;
            down_blocked  <= 1'b0;
            left_blocked  <= 1'b0;
            right_blocked <= 1'b0;
        end else begin
            r_state <= w_next;
            r_idx   <= map_rd ? r_idx + 3'd1 : '0;
            r_pv    <= map_rd;
            r_pi    <= r_idx;
            r_pf    <= w_floor;
            r_ps    <= w_sky;
            r_hits  <= w_hits;
            if (r_state == IDLE && start) begin
                r_x      <= x_position;
                r_y      <= y_position;
                r_scroll <= scroll_x;
                r_hits   <= '0;
            end
            if (r_state == DRAIN) begin
                up_blocked    <= w_hits[P_UP0] | w_hits[P_UP1];
                down_blocked  <= w_hits[P_DOWN0] | w_hits[P_DOWN1];
                left_blocked  <= w_hits[P_LEFT0] | w_hits[P_LEFT1];
                right_blocked <= w_hits[P_RIGHT0] | w_hits[P_RIGHT1];
            end
        end
    end

endmodule

// File: doc/collision_detector.md
COLLISION_DETECTOR -- requirements
Module: collision_detector

Interface
REQ-001 Parameters, one per line (name, default, meaning):
  CHAR_W, 8, character sprite width in pixels.
  CHAR_H, 16, character sprite height in pixels.
  TILE_SHIFT, 3, log2 of tile edge length (8-pixel tiles).
REQ-002 Ports, one per line (name  direction  width  meaning):
  clock  input  1  system clock; all state changes on its rising edge.
  resetn  input  1  reset, synchronous, active-low.
  start  input  1  one-cycle pulse requesting a collision scan (once per frame).
  x_position  input  8  character left edge, screen pixels.
  y_position  input  8  character top edge, screen pixels (0xF0-0xFF = above screen).
  scroll_x  input  8  horizontal world scroll offset, pixels.
  map_addr  output  9  tile-map read address {row[3:0], col[4:0]}.
  map_rd  output  1  tile-map read strobe.
  map_data  input  2  tile code; valid exactly 1 cycle after map_rd; nonzero = solid.
  busy  output  1  high from cycle after accepted start through the done cycle.
  done  output  1  one-cycle pulse; flags updated in this cycle.
  left_blocked, right_blocked, up_blocked, down_blocked  output  1 each  registered collision flags.

Function
REQ-003 The block SHALL sample start only in IDLE; start while busy SHALL be ignored.
REQ-004 On accepted start the block SHALL snapshot x_position, y_position, scroll_x; input changes during a scan SHALL NOT affect it.
REQ-005 States SHALL be IDLE, PROBE, DRAIN, DONE; IDLE->PROBE on start, PROBE->DRAIN after probe 7 issued, DRAIN->DONE, DONE->IDLE.
REQ-006 In PROBE the block SHALL issue probes 0..7 on consecutive cycles with map_rd=1, one per cycle, in order: up(x,y-1), up(x+CHAR_W-1,y-1), down(x,y+CHAR_H), down(x+CHAR_W-1,y+CHAR_H), left(x-1,y), left(x-1,y+CHAR_H-1), right(x+CHAR_W,y), right(x+CHAR_W,y+CHAR_H-1).
REQ-007 Probe world x SHALL be (x + scroll_x + offset) mod 256 (horizontal map wrap); probe y SHALL be (y + offset) mod 256.
REQ-008 map_addr SHALL be {probe_y[6:3], world_x[7:3]}.
REQ-009 Probe y in 0x80-0xEF SHALL be classified solid (world floor) without using map_data; probe y in 0xF0-0xFF SHALL be classified empty (sky); map_rd SHALL still pulse so timing is constant.
REQ-010 Each direction flag SHALL be the OR of its two probe results.
REQ-011 Latency: start sampled at cycle T -> probes at T+1..T+8 -> DRAIN T+9 -> done=1 and new flags at T+10; busy high T+1..T+10.
REQ-012 Flags SHALL update atomically only in the done cycle and hold otherwise.
REQ-013 map_rd SHALL be 0 in IDLE, DRAIN, DONE.
REQ-014 start coincident with done SHALL be ignored; a new start is accepted from T+11.

Reset
REQ-015 resetn=0 at any clock edge, including mid-scan, SHALL force IDLE, abort the scan, and clear busy, done, map_rd, map_addr, and all four flags to 0.
REQ-016 No partial scan result SHALL reach the flags after reset.

Structure
REQ-017 A shared package SHALL hold the state enum, probe index constants, probe offset table, and FLOOR_Y_MIN=0x80 / SKY_Y_MIN=0xF0.
REQ-018 One combinational sub-module, collision_probe_addr, SHALL compute world coordinates, map_addr, and off-map classification for a probe index.
REQ-019 Tile map memory SHALL be external to this block.

Verification
REQ-020 Empty map, x=72, y=40, scroll=0, start -> done at T+10, all flags 0, map_addr sequence matches REQ-006/008.
REQ-021 Map solid only at row 7, col 9; x=72, y=40 -> down_blocked=1 (probe y=56), others 0.
REQ-022 y=0xF8, empty map -> up_blocked=0 (sky); y=0x70 -> down_blocked=1 (floor, y+16=0x80).
REQ-023 x=250, scroll=4, right probe -> world_x=(250+4+8) mod 256=6, col 0; solid col 0 -> right_blocked=1.
REQ-024 Start pulse at T+5 during scan -> ignored, single done at T+10; inputs changed at T+3 -> no effect on result.
REQ-025 resetn=0 at T+6 -> next cycle busy=0, all flags 0, no done pulse; fresh start then completes normally.
